// File: rtl/hash_request_batcher.sv
// Packs a valid/ready stream of search/insert/delete requests into single-cycle
// lane batches for the multi-port XOR hash table, tagging each issued batch.
module hash_request_batcher #(
    parameter int NUM_RD         = 8,
    parameter int NUM_WR         = 4,
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 31,
    parameter int MAX_WAIT       = 4,
    parameter int BATCH_ID_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [KEY_WIDTH-1:0]          in_key,
    input  logic [VALUE_WIDTH-1:0]        in_value,
    input  logic [1:0]                    in_opt,
    input  logic                          issue_en,
    input  logic                          flush_req,
    output logic [NUM_RD*KEY_WIDTH-1:0]   key,
    output logic [NUM_WR*VALUE_WIDTH-1:0] value,
    output logic [2*NUM_WR-1:0]           opt,
    output logic [NUM_WR-1:0]             en_in,
    output logic                          batch_valid,
    output logic [NUM_RD-1:0]             lane_valid,
    output logic [BATCH_ID_WIDTH-1:0]     batch_id
);

    localparam int CNT_W = $clog2(NUM_RD + 1);
    localparam int AGE_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] NUM_RD_C  = CNT_W'(NUM_RD);
    localparam logic [CNT_W-1:0] NUM_WR_C  = CNT_W'(NUM_WR);
    localparam logic [AGE_W-1:0] AGE_MAX_C = AGE_W'(MAX_WAIT - 1);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_wc;
    logic [CNT_W-1:0]          r_rc;
    logic [AGE_W-1:0]          r_age;
    logic [BATCH_ID_WIDTH-1:0] r_id;
    logic [NUM_RD-1:0]         r_laneOcc;
    logic [NUM_RD-1:0]         r_laneWr;
    logic [KEY_WIDTH-1:0]      r_laneKey [NUM_RD];
    logic [VALUE_WIDTH-1:0]    r_laneVal [NUM_WR];
    logic [1:0]                r_laneOpt [NUM_WR];

    logic             w_inWrite;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_keyHit;
    logic             w_conflict;
    logic             w_timeout;
    logic             w_flush;
    logic             w_accept;
    logic [CNT_W-1:0] w_wrPos;
    logic [CNT_W-1:0] w_rdPos;
    logic [CNT_W-1:0] w_wcNext;
    logic [CNT_W-1:0] w_rcNext;
    logic [NUM_RD-1:0] w_wrSel;
    logic [NUM_RD-1:0] w_rdSel;

    assign w_inWrite = (in_opt == 2'b01) || (in_opt == 2'b10);
    assign w_count   = r_wc + r_rc;
    assign w_full    = (w_count == NUM_RD_C);
    assign w_timeout = (r_age == AGE_MAX_C);

    // Search/search on a shared key is harmless; any write involvement is a hazard.
    always_comb begin
        w_keyHit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (r_laneOcc[i] && (r_laneKey[i] == in_key) && (w_inWrite || r_laneWr[i])) begin
                w_keyHit = 1'b1;
            end
        end
    end

    assign w_conflict = (r_state == ST_FILLING) &&
                        ((w_inWrite && (r_wc == NUM_WR_C)) || w_keyHit);

    assign w_flush  = issue_en && (r_state == ST_FILLING) &&
                      (w_full || (in_valid && w_conflict) || w_timeout || flush_req);
    assign in_ready = issue_en || (!w_full && !w_conflict);
    assign w_accept = in_valid && in_ready;

    // A request accepted on a flush cycle opens the fresh batch, so placement restarts.
    assign w_wrPos  = w_flush ? '0 : r_wc;
    assign w_rdPos  = w_flush ? '0 : r_rc;
    assign w_wcNext = w_wrPos + {{(CNT_W-1){1'b0}}, (w_accept && w_inWrite)};
    assign w_rcNext = w_rdPos + {{(CNT_W-1){1'b0}}, (w_accept && !w_inWrite)};

    always_comb begin
        w_wrSel = '0;
        w_rdSel = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_wrSel[i] = (w_wrPos == CNT_W'(i));
            w_rdSel[i] = (w_rdPos == CNT_W'(NUM_RD - 1 - i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_wc        <= '0;
            r_rc        <= '0;
            r_age       <= '0;
            r_id        <= '0;
            r_laneOcc   <= '0;
            r_laneWr    <= '0;
            for (int i = 0; i < NUM_RD; i++) begin
                r_laneKey[i] <= '0;
            end
            for (int w = 0; w < NUM_WR; w++) begin
                r_laneVal[w] <= '0;
                r_laneOpt[w] <= '0;
            end
            batch_valid <= 1'b0;
            lane_valid  <= '0;
            key         <= '0;
            value       <= '0;
            opt         <= '0;
            en_in       <= '0;
            batch_id    <= '0;
        end else begin
            batch_valid <= w_flush;
            if (w_flush) begin
                lane_valid <= r_laneOcc;
                en_in      <= r_laneWr[NUM_WR-1:0];
                batch_id   <= r_id;
                r_id       <= r_id + BATCH_ID_WIDTH'(1);
                for (int i = 0; i < NUM_RD; i++) begin
                    key[i*KEY_WIDTH +: KEY_WIDTH] <= r_laneKey[i];
                end
                for (int w = 0; w < NUM_WR; w++) begin
                    value[w*VALUE_WIDTH +: VALUE_WIDTH] <= r_laneVal[w];
                    opt[2*w +: 2]                       <= r_laneOpt[w];
                end
            end else begin
                lane_valid <= '0;
                en_in      <= '0;
                batch_id   <= '0;
                key        <= '0;
                value      <= '0;
                opt        <= '0;
            end

            // Lanes are wiped on issue so unoccupied or search lanes read back as zero.
            if (w_flush) begin
                r_laneOcc <= '0;
                r_laneWr  <= '0;
                for (int i = 0; i < NUM_RD; i++) begin
                    r_laneKey[i] <= '0;
                end
                for (int w = 0; w < NUM_WR; w++) begin
                    r_laneVal[w] <= '0;
                    r_laneOpt[w] <= '0;
                end
            end

            if (w_accept) begin
                for (int i = 0; i < NUM_RD; i++) begin
                    if (w_inWrite ? w_wrSel[i] : w_rdSel[i]) begin
                        r_laneKey[i] <= in_key;
                        r_laneOcc[i] <= 1'b1;
                        r_laneWr[i]  <= w_inWrite;
                    end
                end
                for (int w = 0; w < NUM_WR; w++) begin
                    if (w_inWrite && w_wrSel[w]) begin
                        r_laneVal[w] <= in_value;
                        r_laneOpt[w] <= in_opt;
                    end
                end
            end

            r_wc    <= w_wcNext;
            r_rc    <= w_rcNext;
            r_state <= ((w_wcNext != '0) || (w_rcNext != '0)) ? ST_FILLING : ST_EMPTY;

            // Age saturates while issue is blocked so a stalled batch goes out first chance.
            if (w_flush || (r_state == ST_EMPTY)) begin
                r_age <= '0;
            end else if (!w_timeout) begin
                r_age <= r_age + AGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_request_batcher.sv
// Randomized and directed bench for hash_request_batcher, checked against a
// request-list reference model of the batching rules.
module tb_hash_request_batcher;

    localparam int NUM_RD   = 8;
    localparam int NUM_WR   = 4;
    localparam int KW       = 32;
    localparam int VW       = 31;
    localparam int MAX_WAIT = 4;
    localparam int IDW      = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [KW-1:0]          in_key = '0;
    logic [VW-1:0]          in_value = '0;
    logic [1:0]             in_opt = '0;
    logic                   issue_en = 1'b0;
    logic                   flush_req = 1'b0;
    logic [NUM_RD*KW-1:0]   key;
    logic [NUM_WR*VW-1:0]   value;
    logic [2*NUM_WR-1:0]    opt;
    logic [NUM_WR-1:0]      en_in;
    logic                   batch_valid;
    logic [NUM_RD-1:0]      lane_valid;
    logic [IDW-1:0]         batch_id;

    always #5 clk = ~clk;

    hash_request_batcher #(
        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .KEY_WIDTH(KW), .VALUE_WIDTH(VW),
        .MAX_WAIT(MAX_WAIT), .BATCH_ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_value(in_value), .in_opt(in_opt),
        .issue_en(issue_en), .flush_req(flush_req),
        .key(key), .value(value), .opt(opt), .en_in(en_in),
        .batch_valid(batch_valid), .lane_valid(lane_valid), .batch_id(batch_id)
    );

    typedef struct {
        logic [KW-1:0] k;
        logic [VW-1:0] v;
        logic [1:0]    op;
        bit            wr;
    } req_t;

    req_t bQ[$];
    int   mAge;
    int   mId;
    int   checks;
    int   errors;

    logic                 eBv;
    logic [NUM_RD-1:0]    eLv;
    logic [NUM_RD*KW-1:0] eKey;
    logic [NUM_WR*VW-1:0] eVal;
    logic [2*NUM_WR-1:0]  eOpt;
    logic [NUM_WR-1:0]    eEn;
    logic [IDW-1:0]       eId;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearExpected();
        eBv  = 1'b0;
        eLv  = '0;
        eKey = '0;
        eVal = '0;
        eOpt = '0;
        eEn  = '0;
        eId  = '0;
    endtask

    // One clock of traffic: drive at negedge, check in_ready, step the model, check outputs.
    task automatic applyStimulus(input bit v, input logic [KW-1:0] k, input logic [VW-1:0] val,
                                 input logic [1:0] op, input bit ie, input bit fr);
        bit inWr, full, conflict, timeout, flush, ready, acc, wasEmpty;
        int nW, wi, si, lane;
        in_valid  = v;
        in_key    = k;
        in_value  = val;
        in_opt    = op;
        issue_en  = ie;
        flush_req = fr;

        inWr     = (op == 2'b01) || (op == 2'b10);
        wasEmpty = (bQ.size() == 0);
        nW       = 0;
        conflict = 1'b0;
        foreach (bQ[i]) begin
            if (bQ[i].wr) nW++;
            if (bQ[i].k == k && (inWr || bQ[i].wr)) conflict = 1'b1;
        end
        if (inWr && nW == NUM_WR) conflict = 1'b1;
        if (wasEmpty) conflict = 1'b0;
        full    = (bQ.size() == NUM_RD);
        timeout = (mAge == MAX_WAIT - 1);
        flush   = ie && !wasEmpty && (full || (v && conflict) || timeout || fr);
        ready   = ie || (!full && !conflict);
        acc     = v && ready;

        #1;
        checkOutput("in_ready", in_ready, ready);
        @(posedge clk);

        clearExpected();
        eBv = flush;
        if (flush) begin
            wi = 0;
            si = 0;
            foreach (bQ[i]) begin
                if (bQ[i].wr) begin
                    lane = wi;
                    wi++;
                    eEn[lane]         = 1'b1;
                    eOpt[2*lane +: 2] = bQ[i].op;
                    eVal[lane*VW +: VW] = bQ[i].v;
                end else begin
                    lane = NUM_RD - 1 - si;
                    si++;
                end
                eLv[lane]           = 1'b1;
                eKey[lane*KW +: KW] = bQ[i].k;
            end
            eId = IDW'(mId);
            mId = (mId + 1) % (1 << IDW);
        end
        if (flush || wasEmpty) mAge = 0;
        else if (!timeout) mAge++;
        if (flush) bQ.delete();
        if (acc) bQ.push_back('{k, val, op, inWr});

        @(negedge clk);
        checkOutput("batch_valid", batch_valid, eBv);
        checkOutput("lane_valid", lane_valid, eLv);
        checkOutput("key", key, eKey);
        checkOutput("value", value, eVal);
        checkOutput("opt", opt, eOpt);
        checkOutput("en_in", en_in, eEn);
        if (eBv) checkOutput("batch_id", batch_id, eId);
    endtask

    task automatic applyReset();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_batch_valid", batch_valid, 1'b0);
        checkOutput("rst_lane_valid", lane_valid, '0);
        checkOutput("rst_key", key, '0);
        checkOutput("rst_value", value, '0);
        checkOutput("rst_opt", opt, '0);
        checkOutput("rst_en_in", en_in, '0);
        checkOutput("rst_batch_id", batch_id, '0);
        bQ.delete();
        mAge = 0;
        mId  = 0;
        clearExpected();
        in_valid  = 1'b0;
        issue_en  = 1'b0;
        flush_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        bit found;
        int n;
        checks = 0;
        errors = 0;
        mAge   = 0;
        mId    = 0;
        clearExpected();
        @(negedge clk);
        applyReset();

        $display("[TB] reset mid-fill");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, KW'(i), '0, 2'b00, 1'b0, 1'b0);
        applyReset();
        applyStimulus(1'b1, 32'h77, '0, 2'b00, 1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
            if (batch_valid) begin
                found = 1'b1;
                checkOutput("firstIdAfterReset", batch_id, '0);
            end
        end
        checkOutput("firstBatchSeen", found, 1'b1);

        $display("[TB] eight searches");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, KW'(i), VW'($urandom), 2'b00, 1'b1, 1'b0);
        idle(8);

        $display("[TB] five inserts");
        for (int i = 'hA; i <= 'hE; i++) applyStimulus(1'b1, KW'(i), VW'($urandom), 2'b01, 1'b1, 1'b0);
        idle(8);

        $display("[TB] insert then search same key");
        applyStimulus(1'b1, 32'h10, VW'(31'h1234), 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h10, '0, 2'b00, 1'b1, 1'b0);
        idle(8);

        $display("[TB] single search latency");
        applyStimulus(1'b1, 32'h55, '0, 2'b00, 1'b1, 1'b0);
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
            n++;
            if (batch_valid) begin
                found = 1'b1;
                checkOutput("latencyLane7", key[NUM_RD*KW-1 -: KW], 32'h55);
            end
        end
        checkOutput("latency", n, MAX_WAIT);
        idle(2);

        $display("[TB] stalled fill then release");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, KW'(32 + i), '0, 2'b00, 1'b0, 1'b0);
        checkOutput("stalledFullReady", in_ready, 1'b0);
        applyStimulus(1'b1, KW'(40), '0, 2'b00, 1'b1, 1'b0);
        idle(8);

        $display("[TB] forced flushes for id wrap");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, KW'(i), VW'($urandom), 2'($urandom_range(0, 3)), 1'b1, 1'b1);
        idle(8);

        $display("[TB] random traffic");
        for (int c = 0; c < 1200; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, KW'($urandom_range(0, 11)), VW'($urandom),
                          2'($urandom_range(0, 3)),
                          ((c / 40) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 8),
                          $urandom_range(0, 19) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
